serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serializer.sv | 112 +++++++++++
 tb/tb_serializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// Parallel-to-serial shifter with direction strobes, frame abort and done pulse.
// Define SERIALIZER_PARITY_EN to append one even-parity bit after the data bits.
module serializer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  dir,
    input  logic                  cl,
    output logic                  sout,
    output logic                  sr_out,
    output logic                  sl_out,
    output logic                  done
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
    logic par_q;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] sh_q;
    logic                  dir_q;

    // sh_q always holds the bit currently on sout at the end it is shifted out of.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sh_q     <= '0;
            dir_q    <= 1'b0;
            in_ready <= 1'b1;
            sout     <= 1'b0;
            sr_out   <= 1'b0;
            sl_out   <= 1'b0;
            done     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            sout   <= 1'b0;
            sr_out <= 1'b0;
            sl_out <= 1'b0;
            done   <= 1'b0;
            if (cl) begin
                state    <= IDLE;
                in_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            sh_q     <= in;
                            dir_q    <= dir;
                            cnt      <= '0;
                            state    <= SHIFT;
                            in_ready <= 1'b0;
                            sout     <= dir ? in[DATA_WIDTH-1] : in[0];
                            sr_out   <= ~dir;
                            sl_out   <= dir;
`ifdef SERIALIZER_PARITY_EN
                            par_q    <= ^in;
`endif
                        end
                    end
                    SHIFT: begin
                        if (cnt == LAST) begin
`ifdef SERIALIZER_PARITY_EN
                            state  <= PARITY;
                            sout   <= par_q;
                            sr_out <= ~dir_q;
                            sl_out <= dir_q;
`else
                            state  <= DONE;
                            done   <= 1'b1;
`endif
                        end else begin
                            cnt    <= cnt + CW'(1);
                            sh_q   <= dir_q ? (sh_q << 1) : (sh_q >> 1);
                            sout   <= dir_q ? sh_q[DATA_WIDTH-2] : sh_q[1];
                            sr_out <= ~dir_q;
                            sl_out <= dir_q;
                        end
                    end
`ifdef SERIALIZER_PARITY_EN
                    PARITY: begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
`endif
                    DONE: begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: vector table, corner sequences, random vs queue model.
module tb_serializer;

    localparam int W = 16;
`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F = W + 1 + PAR;   // accept edge to done pulse, in cycles

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, dir, cl;
    logic [W-1:0] din;
    logic         sout, sr_out, sl_out, done;

    int errors = 0;
    int checks = 0;

    serializer #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (din),
        .dir      (dir),
        .cl       (cl),
        .sout     (sout),
        .sr_out   (sr_out),
        .sl_out   (sl_out),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] word;
        logic         d;
        logic [W-1:0] stream;  // bit k = value expected on sout in shift cycle k
        logic         par;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {in_ready, sout, sr_out, sl_out, done};
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < F + 10; i++) begin
            if (in_ready) break;
            tick();
        end
        chk("wait_idle", in_ready, 1'b1);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        logic [W-1:0] got, rx;
        logic par_bit;
        int done_cyc;
        bit strobe_ok, rdy_ok;
        wait_idle();
        din = v.word; dir = v.d; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; din = ~v.word; dir = ~v.d;
        got = '0; rx = '0; par_bit = 1'b0; done_cyc = -1; strobe_ok = 1; rdy_ok = 1;
        for (int c = 1; c <= F + 4; c++) begin
            if (in_ready) rdy_ok = 0;
            if (done) begin
                done_cyc = c;
                if (sout || sr_out || sl_out) strobe_ok = 0;
                break;
            end
            if (c <= W + PAR) begin
                if (sr_out !== ~v.d || sl_out !== v.d) strobe_ok = 0;
                if (c <= W) begin
                    got[c-1] = sout;
                    if (sr_out) rx = {sout, rx[W-1:1]};
                    else if (sl_out) rx = {rx[W-2:0], sout};
                end else begin
                    par_bit = sout;
                end
            end else if (sr_out || sl_out) begin
                strobe_ok = 0;
            end
            tick();
        end
        chk({tag, "_stream"}, got, v.stream);
        chk({tag, "_strobes"}, strobe_ok, 1'b1);
        chk({tag, "_latency"}, done_cyc, F);
        chk({tag, "_receiver"}, rx, v.word);
        chk({tag, "_ready_low"}, rdy_ok, 1'b1);
`ifdef SERIALIZER_PARITY_EN
        chk({tag, "_parity"}, par_bit, v.par);
`endif
        tick();
        chk({tag, "_back_idle"}, outs(), 5'b10000);
    endtask

    vec_t tbl[9];

    localparam logic [4:0] IDLE_T = 5'b10000;
    logic [4:0] q[$];
    logic [4:0] exp_cur;

    initial begin
        tbl[0] = '{16'hA5C3, 1'b0, 16'hA5C3, 1'b0};
        tbl[1] = '{16'hA5C3, 1'b1, 16'hC3A5, 1'b0};
        tbl[2] = '{16'h0001, 1'b0, 16'h0001, 1'b1};
        tbl[3] = '{16'h0001, 1'b1, 16'h8000, 1'b1};
        tbl[4] = '{16'h8000, 1'b1, 16'h0001, 1'b1};
        tbl[5] = '{16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        tbl[6] = '{16'h0000, 1'b1, 16'h0000, 1'b0};
        tbl[7] = '{16'h1234, 1'b1, 16'h2C48, 1'b1};
        tbl[8] = '{16'h0007, 1'b0, 16'h0007, 1'b1};

        rst = 1'b1; in_valid = 1'b1; cl = 1'b1; din = 16'hFFFF; dir = 1'b1;
        tick();
        tick();
        chk("reset_outputs", outs(), 5'b10000);
        rst = 1'b0; in_valid = 1'b0; cl = 1'b0; din = '0; dir = 1'b0;
        tick();
        chk("after_reset", outs(), 5'b10000);

        for (int i = 0; i < 9; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

        // back-to-back with in_valid held high
        begin
            int nd, d1, d2, rdy_cnt, one2;
            wait_idle();
            din = 16'h0001; dir = 1'b0; in_valid = 1'b1;
            tick();
            din = 16'h8000;
            nd = 0; d1 = -1; d2 = -1; rdy_cnt = 0; one2 = -1;
            for (int c = 1; c <= 2 * F + 6; c++) begin
                if (done) begin
                    nd++;
                    if (nd == 1) d1 = c; else if (nd == 2) d2 = c;
                end
                if (in_ready && c <= 2 * F + 1) rdy_cnt++;
                if (sout && d1 > 0 && one2 < 0) one2 = c;
                if (c == F + 2) in_valid = 1'b0;
                tick();
            end
            chk("b2b_done_count", nd, 2);
            chk("b2b_done1", d1, F);
            chk("b2b_done2", d2, 2 * F + 1);
            chk("b2b_idle_cycles", rdy_cnt, 1);
            chk("b2b_frame2_msb", one2, F + 2 + (W - 1));
        end

        // abort on shift cycle 5
        begin
            int bad;
            wait_idle();
            din = 16'hA5C3; dir = 1'b0; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (5) tick();
            chk("cl_pre_strobe", sr_out, 1'b1);
            cl = 1'b1;
            tick();
            cl = 1'b0;
            chk("cl_idle", outs(), 5'b10000);
            bad = 0;
            for (int c = 0; c < F + 3; c++) begin
                if (done || sr_out || sl_out || !in_ready) bad++;
                tick();
            end
            chk("cl_no_done", bad, 0);
        end

        // reset on shift cycle 9
        begin
            int bad;
            wait_idle();
            din = 16'hA5C3; dir = 1'b1; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (9) tick();
            chk("rst_pre_strobe", sl_out, 1'b1);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("rst_idle", outs(), 5'b10000);
            bad = 0;
            for (int c = 0; c < F + 3; c++) begin
                if (done || sr_out || sl_out || !in_ready) bad++;
                tick();
            end
            chk("rst_no_done", bad, 0);
        end

        // cl wins over in_valid in IDLE
        wait_idle();
        cl = 1'b1; in_valid = 1'b1; din = 16'hFFFF;
        tick();
        chk("cl_blocks_accept", outs(), 5'b10000);
        cl = 1'b0; in_valid = 1'b0;
        tick();
        chk("cl_blocks_no_frame", outs(), 5'b10000);

        // randomized traffic against a transaction-queue model
        exp_cur = IDLE_T;
        q.delete();
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] w;
            logic d, v, c_in, r_in;
            w = W'($urandom);
            d = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 2) != 0);
            c_in = ($urandom_range(0, 59) == 0);
            r_in = (i == 0) || ($urandom_range(0, 199) == 0);
            din = w; dir = d; in_valid = v; cl = c_in; rst = r_in;
            if (r_in || c_in) begin
                q.delete();
                exp_cur = IDLE_T;
            end else if (exp_cur[4] && v) begin
                for (int k = 0; k < W; k++)
                    q.push_back({1'b0, (d ? w[W-1-k] : w[k]), ~d, d, 1'b0});
`ifdef SERIALIZER_PARITY_EN
                q.push_back({1'b0, ^w, ~d, d, 1'b0});
`endif
                q.push_back(5'b00001);
                exp_cur = q.pop_front();
            end else if (q.size() > 0) begin
                exp_cur = q.pop_front();
            end else begin
                exp_cur = IDLE_T;
            end
            tick();
            chk($sformatf("rand_cycle%0d", i), outs(), exp_cur);
        end
        rst = 1'b0; cl = 1'b0; in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
